// File: rtl/exmem_skid_pipe.sv
// ============================================================================
// exmem_skid_pipe : EX->MEM 2-entry skid buffer with two forwarding lookups
// Revision 1.0
// ============================================================================
`default_nettype none

module exmem_skid_pipe #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8,
  parameter int RA_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic              alu_stall_i,
  output logic              in_ready_o,
  input  logic [XLEN-1:0]   alu_result_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  logic [RA_W-1:0]   rd_addr_i,
  input  logic              rd_we_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   out_result_o,
  output logic [XLEN-1:0]   out_store_data_o,
  output logic [RA_W-1:0]   out_rd_addr_o,
  output logic              out_rd_we_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [XLEN-1:0]   out_pc_o,
  input  logic [RA_W-1:0]   fwd_rs1_addr_i,
  input  logic [RA_W-1:0]   fwd_rs2_addr_i,
  output logic              fwd_rs1_hit_o,
  output logic [XLEN-1:0]   fwd_rs1_data_o,
  output logic              fwd_rs2_hit_o,
  output logic [XLEN-1:0]   fwd_rs2_data_o,
  output logic [1:0]        occupancy_o
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        valid_q, valid_d;
  logic [XLEN-1:0]   result_q [2];
  logic [XLEN-1:0]   result_d [2];
  logic [XLEN-1:0]   store_q  [2];
  logic [XLEN-1:0]   store_d  [2];
  logic [RA_W-1:0]   rd_addr_q [2];
  logic [RA_W-1:0]   rd_addr_d [2];
  logic [1:0]        rd_we_q, rd_we_d;
  logic [CTRL_W-1:0] ctrl_q [2];
  logic [CTRL_W-1:0] ctrl_d [2];
  logic [XLEN-1:0]   pc_q [2];
  logic [XLEN-1:0]   pc_d [2];

  logic push;
  logic pop;

  assign in_ready_o  = (count_q != ST_FULL);
  assign out_valid_o = (count_q != ST_EMPTY);
  assign occupancy_o = count_q;
  assign push = in_valid_i & ~alu_stall_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i & ~flush_i;

  assign out_result_o     = result_q[rd_ptr_q];
  assign out_store_data_o = store_q[rd_ptr_q];
  assign out_rd_addr_o    = rd_addr_q[rd_ptr_q];
  assign out_rd_we_o      = rd_we_q[rd_ptr_q];
  assign out_ctrl_o       = ctrl_q[rd_ptr_q];
  assign out_pc_o         = pc_q[rd_ptr_q];

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    rd_we_d  = rd_we_q;
    for (int i = 0; i < 2; i++) begin
      result_d[i]  = result_q[i];
      store_d[i]   = store_q[i];
      rd_addr_d[i] = rd_addr_q[i];
      ctrl_d[i]    = ctrl_q[i];
      pc_d[i]      = pc_q[i];
    end

    if (flush_i) begin
      count_d  = ST_EMPTY;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      valid_d  = 2'b00;
    end else begin
      if (push) begin
        result_d[wr_ptr_q]  = alu_result_i;
        store_d[wr_ptr_q]   = store_data_i;
        rd_addr_d[wr_ptr_q] = rd_addr_i;
        // x0 is architecturally constant, so it is never marked writable
        rd_we_d[wr_ptr_q]   = rd_we_i & (rd_addr_i != '0);
        ctrl_d[wr_ptr_q]    = ctrl_i;
        pc_d[wr_ptr_q]      = pc_i;
        valid_d[wr_ptr_q]   = 1'b1;
        wr_ptr_d            = ~wr_ptr_q;
      end
      if (pop) begin
        valid_d[rd_ptr_q] = 1'b0;
        rd_ptr_d          = ~rd_ptr_q;
      end
      case (count_q)
        ST_EMPTY: if (push) count_d = ST_ONE;
        ST_ONE: begin
          case ({push, pop})
            2'b10:   count_d = ST_FULL;
            2'b01:   count_d = ST_EMPTY;
            default: count_d = ST_ONE;
          endcase
        end
        ST_FULL:  if (pop) count_d = ST_ONE;
        default:  count_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q  <= ST_EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      valid_q  <= 2'b00;
      rd_we_q  <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        result_q[i]  <= '0;
        store_q[i]   <= '0;
        rd_addr_q[i] <= '0;
        ctrl_q[i]    <= '0;
        pc_q[i]      <= '0;
      end
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      rd_we_q  <= rd_we_d;
      for (int i = 0; i < 2; i++) begin
        result_q[i]  <= result_d[i];
        store_q[i]   <= store_d[i];
        rd_addr_q[i] <= rd_addr_d[i];
        ctrl_q[i]    <= ctrl_d[i];
        pc_q[i]      <= pc_d[i];
      end
    end
  end

  // Both entries are valid only when FULL, and then the one away from rd_ptr is younger
  logic       yng;
  logic [1:0] m1;
  logic [1:0] m2;

  assign yng = ~rd_ptr_q;

  always_comb begin
    fwd_rs1_hit_o  = 1'b0;
    fwd_rs1_data_o = '0;
    fwd_rs2_hit_o  = 1'b0;
    fwd_rs2_data_o = '0;
    for (int i = 0; i < 2; i++) begin
      m1[i] = valid_q[i] & rd_we_q[i] & (rd_addr_q[i] == fwd_rs1_addr_i) & (fwd_rs1_addr_i != '0);
      m2[i] = valid_q[i] & rd_we_q[i] & (rd_addr_q[i] == fwd_rs2_addr_i) & (fwd_rs2_addr_i != '0);
    end
    if (m1[yng]) begin
      fwd_rs1_hit_o  = 1'b1;
      fwd_rs1_data_o = result_q[yng];
    end else if (m1[rd_ptr_q]) begin
      fwd_rs1_hit_o  = 1'b1;
      fwd_rs1_data_o = result_q[rd_ptr_q];
    end
    if (m2[yng]) begin
      fwd_rs2_hit_o  = 1'b1;
      fwd_rs2_data_o = result_q[yng];
    end else if (m2[rd_ptr_q]) begin
      fwd_rs2_hit_o  = 1'b1;
      fwd_rs2_data_o = result_q[rd_ptr_q];
    end
  end

endmodule

`default_nettype wire

// File: doc/exmem_skid_pipe.md
Name: exmem_skid_pipe

Overview:
- Execute-to-memory pipeline boundary that captures each completed ALU/MDU result from the execute stage.
- Holds results in a 2-entry skid buffer and presents them in order to the memory stage over a valid/ready handshake.
- Decouples multi-cycle ALU stalls from memory-stage backpressure.
- Provides two combinational forwarding lookup ports so decode/execute can bypass results still in flight.

Parameters:
- XLEN, 32, datapath width of result, store data and PC
- CTRL_W, 8, width of opaque memory-stage control bundle (load/store type, size, sign)
- RA_W, 5, register address width

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  asynchronous, active-high reset
- in_valid_i  input  1  execute stage offers an instruction
- alu_stall_i  input  1  ALU result not final (multi-cycle MUL/DIV busy); offer ignored while high
- in_ready_o  output  1  buffer can accept a push this cycle
- alu_result_i  input  XLEN  ALU output / effective address
- store_data_i  input  XLEN  rs2 value for stores
- rd_addr_i  input  RA_W  destination register
- rd_we_i  input  1  destination write enable
- ctrl_i  input  CTRL_W  memory-stage control bundle
- pc_i  input  XLEN  instruction PC
- flush_i  input  1  discard all buffered and incoming entries
- out_valid_o  output  1  head entry valid
- out_ready_i  input  1  memory stage consumes head
- out_result_o  output  XLEN  head result
- out_store_data_o  output  XLEN  head store data
- out_rd_addr_o  output  RA_W  head rd
- out_rd_we_o  output  1  head rd write enable
- out_ctrl_o  output  CTRL_W  head control bundle
- out_pc_o  output  XLEN  head PC
- fwd_rs1_addr_i  input  RA_W  lookup address, port 1
- fwd_rs2_addr_i  input  RA_W  lookup address, port 2
- fwd_rs1_hit_o  output  1  port 1 matched a buffered entry
- fwd_rs1_data_o  output  XLEN  port 1 forwarded value
- fwd_rs2_hit_o  output  1  port 2 matched a buffered entry
- fwd_rs2_data_o  output  XLEN  port 2 forwarded value
- occupancy_o  output  2  entries held (0..2)

Behaviour:
- Storage: 2 entries; registered 1-bit wr_ptr and rd_ptr; state EMPTY/ONE/FULL (encoded as count 0/1/2, mirrored on occupancy_o).
- Reset (async, rst_i high):
  - count=0, both pointers=0, all entry valid bits=0, entry payloads=0.
  - Outputs: out_valid_o=0, in_ready_o=1, fwd hits=0, all data outputs=0.
  - Reset asserted mid-transfer drops every entry immediately; nothing is replayed.
- Control signals:
  - in_ready_o = (count != FULL). Derived from registered state only; never combinationally depends on out_ready_i or in_valid_i.
  - push = in_valid_i & ~alu_stall_i & in_ready_o & ~flush_i.
  - pop = out_valid_o & out_ready_i & ~flush_i.
- Push: writes entry[wr_ptr]; wr_ptr toggles.
  - rd_we is stored as rd_we_i & (rd_addr_i != 0), so x0 is never written or forwarded.
- Pop: rd_ptr toggles.
- Transitions:
  - EMPTY: push → ONE.
  - ONE: push only → FULL; pop only → EMPTY; push+pop or neither → ONE.
  - FULL: pop → ONE; push impossible (in_ready_o=0).
- Latency and throughput: 1 cycle from accepted push to out_valid_o. Sustained 1 entry/cycle when out_ready_i is held high.
- Output: out_* driven from entry[rd_ptr] with out_valid_o = (count != 0).
  - While out_valid_o=1 and out_ready_i=0, all out_* hold stable.
- Flush (priority over push and pop): next edge count=0 and both pointers=0.
  - The same-cycle offer is discarded and no pop is counted.
  - in_ready_o=1 the cycle after flush.
- Forwarding, per port, purely combinational on current state:
  - Hit when a valid entry has rd_we=1 and rd_addr equals the lookup address.
  - If both entries hit, the younger entry (the one not at rd_ptr when count=FULL) wins.
  - On a hit, data = that entry's result. On a miss, hit=0 and data=0.
  - Address 0 never hits.
  - Forwarding ignores flush_i in the current cycle; flushed entries stop hitting from the next cycle.
- Arithmetic: none on the datapath; pointers wrap modulo 2.

Test Plan:
- Reset mid-stream: two entries loaded, assert rst_i asynchronously → occupancy_o=0, out_valid_o=0, in_ready_o=1 before the next clock edge.
- Backpressure fill: push results 0x11, 0x22, 0x33 on consecutive cycles with out_ready_i=0 → occupancy_o=2, in_ready_o=0 after the second push, 0x33 not accepted; then raise out_ready_i → pops 0x11 then 0x22, in order.
- Stall gating: in_valid_i=1 for 3 cycles with alu_stall_i=1,1,0 and alu_result_i=0xDEAD0001 → exactly one entry is captured, on the third cycle; out_valid_o rises one cycle later.
- Streaming with simultaneous push/pop at count=1 and out_ready_i=1: 8 back-to-back pushes → occupancy_o stays 1, all 8 results appear in order, one per cycle.
- Forwarding priority: buffer holds rd=5/0xAAAA (older) and rd=5/0xBBBB (younger); lookup 5 → hit, 0xBBBB. Lookup 0 with an x0 entry present → no hit. Lookup 7 → hit=0, data=0.
- Flush with concurrent push and pop at FULL → next cycle occupancy_o=0, out_valid_o=0, the offered entry is absent, and forwarding hits clear.
